// File: rtl/tl45_pkg.sv
// Shared TL45 definitions: opcode constants, the NOP bubble encoding and the fetch FSM state type.
package tl45_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [31:0] NOP_INST = 32'hF000_0000;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT_DS = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/tl45_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, fetch->decode buffer, stall/redirect and debug state.
interface tl45_fetch_if #(parameter int ADDR_W = 16);

  // Memory: a transfer completes in any cycle with o_mem_req && i_mem_ack; i_mem_data is valid
  // only then, and o_mem_addr stays stable from the first cycle of o_mem_req until that cycle.
  logic                     o_mem_req;
  logic [ADDR_W-1:0]        o_mem_addr;
  logic                     i_mem_ack;
  logic [31:0]              i_mem_data;

  logic                     i_pipe_stall;
  logic                     i_redirect;
  logic [31:0]              i_redirect_pc;

  logic [31:0]              o_buf_pc;
  logic [31:0]              o_buf_inst;
  logic                     o_halted;
  tl45_pkg::fetch_state_t   o_dbg_state;

  modport master (
    input  i_mem_ack, i_mem_data, i_pipe_stall, i_redirect, i_redirect_pc,
    output o_mem_req, o_mem_addr, o_buf_pc, o_buf_inst, o_halted, o_dbg_state
  );

  modport slave (
    output i_mem_ack, i_mem_data, i_pipe_stall, i_redirect, i_redirect_pc,
    input  o_mem_req, o_mem_addr, o_buf_pc, o_buf_inst, o_halted, o_dbg_state
  );

endinterface

// File: rtl/tl45_fetch_skid.sv
// One-entry {pc, inst} holding register that parks a fetched instruction while decode is stalled.
module tl45_fetch_skid
  import tl45_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  logic        valid_d, valid_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] inst_d, inst_q;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      inst_d  = in_inst;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid    = valid_q;
  assign out_pc   = pc_q;
  assign out_inst = inst_q;

endmodule

// File: rtl/tl45_fetch.sv
// TL45 instruction fetch: req/ack memory reads into the fetch->decode buffer with stall and redirect.
// Optional HALT support is compiled in with TL45_FETCH_HALT_EN.
module tl45_fetch
  import tl45_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          ADDR_W   = 16
) (
  input logic          i_clk,
  input logic          i_reset_n,
  tl45_fetch_if.master bus
);

`ifdef TL45_FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  function automatic logic halt_hit(input logic [31:0] inst);
    return HALT_EN && (inst[31:28] == OP_HALT);
  endfunction

  fetch_state_t      state_d, state_q;
  logic [31:0]       pc_d, pc_q;
  logic              discard_d, discard_q;
  logic              mem_req_d, mem_req_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [31:0]       buf_pc_d, buf_pc_q;
  logic [31:0]       buf_inst_d, buf_inst_q;

  logic              skid_load, skid_unload, skid_clear, skid_valid;
  logic [31:0]       skid_pc, skid_inst;
  logic              ack_fire;

  assign ack_fire = mem_req_q && bus.i_mem_ack;

  tl45_fetch_skid u_skid (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .in_pc    (pc_q),
    .in_inst  (bus.i_mem_data),
    .valid    (skid_valid),
    .out_pc   (skid_pc),
    .out_inst (skid_inst)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    // Decode sees a bubble in every unstalled cycle that delivers nothing new.
    if (!bus.i_pipe_stall) begin
      buf_pc_d   = '0;
      buf_inst_d = NOP_INST;
    end

    if (bus.i_redirect) begin
      // The buffered instruction is younger than the branch, so it is squashed even under stall.
      pc_d       = bus.i_redirect_pc;
      state_d    = REQ;
      skid_clear = 1'b1;
      buf_pc_d   = '0;
      buf_inst_d = NOP_INST;
      discard_d  = mem_req_q && !bus.i_mem_ack;
    end else begin
      case (state_q)
        REQ: begin
          if (ack_fire) begin
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              pc_d = pc_q + 32'd1;
              if (bus.i_pipe_stall) begin
                skid_load = 1'b1;
                state_d   = WAIT_DS;
              end else begin
                buf_pc_d   = pc_q;
                buf_inst_d = bus.i_mem_data;
                if (halt_hit(bus.i_mem_data)) state_d = HALTED;
              end
            end
          end
        end
        WAIT_DS: begin
          if (!bus.i_pipe_stall && skid_valid) begin
            buf_pc_d    = skid_pc;
            buf_inst_d  = skid_inst;
            skid_unload = 1'b1;
            state_d     = halt_hit(skid_inst) ? HALTED : REQ;
          end
        end
        default: ;
      endcase
    end

    mem_req_d  = (state_d == REQ);
    // An un-acked request keeps its address even if pc has already moved to a redirect target.
    mem_addr_d = (mem_req_q && !bus.i_mem_ack) ? mem_addr_q : pc_d[ADDR_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      buf_pc_q   <= '0;
      buf_inst_q <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_buf_pc    = buf_pc_q;
  assign bus.o_buf_inst  = buf_inst_q;
  assign bus.o_dbg_state = state_q;
`ifdef TL45_FETCH_HALT_EN
  assign bus.o_halted    = (state_q == HALTED);
`else
  assign bus.o_halted    = 1'b0;
`endif

endmodule

// File: tb/tb_tl45_fetch.sv
// Self-checking bench for tl45_fetch: gated wait-state memory model, expected-delivery queue and monitor.
module tb_tl45_fetch;
  import tl45_pkg::*;

  localparam int ADDR_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl45_fetch_if #(.ADDR_W(ADDR_W)) bus();

  tl45_fetch #(.RESET_PC(32'h0), .ADDR_W(ADDR_W)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  // Acks only while acks_done < ack_limit, after wait_states cycles of the request.
  logic [31:0] mem [0:255];
  int ack_limit   = 0;
  int wait_states = 0;
  int acks_done   = 0;
  int ws_cnt      = 0;

  assign bus.i_mem_ack  = bus.o_mem_req && (acks_done < ack_limit) && (ws_cnt >= wait_states);
  assign bus.i_mem_data = mem[bus.o_mem_addr[7:0]];

  always @(posedge clk) begin
    if (bus.o_mem_req && bus.i_mem_ack) begin
      acks_done <= acks_done + 1;
      ws_cnt    <= 0;
    end else if (bus.o_mem_req && (acks_done < ack_limit)) begin
      ws_cnt <= ws_cnt + 1;
    end else begin
      ws_cnt <= 0;
    end
  end

  // ---------------- monitor ----------------
  logic        late_stall;
  logic        late_pend = 1'b0;
  logic [15:0] late_addr;

  always @(negedge clk) begin
    #4;
    late_stall = bus.i_pipe_stall;
    late_pend  = rst_n && bus.o_mem_req && !bus.i_mem_ack;
    late_addr  = bus.o_mem_addr;
  end

  always @(posedge clk) begin
    logic [63:0] e;
    #1;
    if (rst_n) begin
      if (late_pend) begin
        check("addr_stable", 32'(bus.o_mem_addr), 32'(late_addr));
        check("req_held", 32'(bus.o_mem_req), 32'd1);
      end
      if (!late_stall && bus.o_buf_inst !== NOP_INST) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", bus.o_buf_inst, NOP_INST);
        end else begin
          e = exp_q.pop_front();
          check("buf_pc", bus.o_buf_pc, e[63:32]);
          check("buf_inst", bus.o_buf_inst, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({pc, inst});
  endtask

  task automatic wait_inst(input logic [31:0] exp, output int bubbles);
    int cyc = 0;
    bubbles = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.o_buf_inst === NOP_INST) bubbles++;
    end while (bus.o_buf_inst !== exp && cyc < 40);
    check("wait_inst", bus.o_buf_inst, exp);
  endtask

  task automatic release_and_check_start();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("start_req", 32'(bus.o_mem_req), 32'd1);
    check("start_addr", 32'(bus.o_mem_addr), 32'd0);
    check("start_bubble", bus.o_buf_inst, NOP_INST);
    @(negedge clk);
    check("first_pc", bus.o_buf_pc, 32'd0);
    check("first_inst", bus.o_buf_inst, 32'h0000_1000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int b;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + i;
    bus.i_pipe_stall  = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(bus.o_mem_req), 32'd0);
    check("rst_addr", 32'(bus.o_mem_addr), 32'd0);
    check("rst_buf_pc", bus.o_buf_pc, 32'd0);
    check("rst_buf_inst", bus.o_buf_inst, NOP_INST);
    check("rst_halted", 32'(bus.o_halted), 32'd0);
    check("rst_state", 32'(bus.o_dbg_state), 32'(REQ));

    // 1: zero-wait back-to-back
    ack_limit = acks_done + 3;
    push_exp(32'd0, 32'h1000); push_exp(32'd1, 32'h1001); push_exp(32'd2, 32'h1002);
    release_and_check_start();
    wait_inst(32'h1001, b);
    check("b2b_gap01", 32'(b), 32'd0);
    wait_inst(32'h1002, b);
    check("b2b_gap12", 32'(b), 32'd0);
    repeat (2) @(negedge clk);

    // 2: two wait states -> two bubbles between instructions
    wait_states = 2;
    ack_limit   = acks_done + 2;
    push_exp(32'd3, 32'h1003); push_exp(32'd4, 32'h1004);
    wait_inst(32'h1003, b);
    wait_inst(32'h1004, b);
    check("ws_bubbles", 32'(b), 32'd2);

    // 3: stall for 3 cycles while pc 5 is acked
    bus.i_pipe_stall = 1'b1;
    wait_states = 0;
    ack_limit   = acks_done + 2;
    push_exp(32'd5, 32'h1005); push_exp(32'd6, 32'h1006);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", bus.o_buf_inst, 32'h1004);
      check("stall_req", 32'(bus.o_mem_req), 32'd0);
    end
    check("stall_state", 32'(bus.o_dbg_state), 32'(WAIT_DS));
    bus.i_pipe_stall = 1'b0;
    wait_inst(32'h1005, b);
    wait_inst(32'h1006, b);
    check("unstall_gap", 32'(b), 32'd0);

    // 4: redirect to 0x40 while pc 8 waits for its ack
    ack_limit = acks_done + 1;
    push_exp(32'd7, 32'h1007);
    wait_inst(32'h1007, b);
    wait_states = 2;
    ack_limit   = acks_done + 2;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h40;
    push_exp(32'h40, 32'h1040);
    @(negedge clk);
    bus.i_redirect = 1'b0;
    check("redir_addr_hold", 32'(bus.o_mem_addr), 32'd8);
    check("redir_bubble", bus.o_buf_inst, NOP_INST);
    wait_inst(32'h1040, b);
    check("redir_bubbles", 32'(b), 32'd4);
    check("redir_pc", bus.o_buf_pc, 32'h40);

    // 6: async reset mid-request, then restart at RESET_PC
    wait_states = 0;
    @(negedge clk);
    check("pre_rst_req", 32'(bus.o_mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(bus.o_mem_req), 32'd0);
    check("arst_addr", 32'(bus.o_mem_addr), 32'd0);
    check("arst_buf_inst", bus.o_buf_inst, NOP_INST);
    mem[3] = 32'h7000_0000;
    push_exp(32'd0, 32'h1000); push_exp(32'd1, 32'h1001);
    push_exp(32'd2, 32'h1002); push_exp(32'd3, 32'h7000_0000);
`ifdef TL45_FETCH_HALT_EN
    ack_limit = acks_done + 4;
`else
    ack_limit = acks_done + 5;
    push_exp(32'd4, 32'h1004);
`endif
    @(negedge clk);
    release_and_check_start();

    // 5: HALT handling
    wait_inst(32'h7000_0000, b);
`ifdef TL45_FETCH_HALT_EN
    check("halt_flag", 32'(bus.o_halted), 32'd1);
    check("halt_req", 32'(bus.o_mem_req), 32'd0);
    repeat (3) @(negedge clk);
    check("halt_stay_req", 32'(bus.o_mem_req), 32'd0);
    check("halt_state", 32'(bus.o_dbg_state), 32'(HALTED));
    ack_limit = acks_done + 1;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h10;
    push_exp(32'h10, 32'h1010);
    @(negedge clk);
    bus.i_redirect = 1'b0;
    check("resume_halted", 32'(bus.o_halted), 32'd0);
    check("resume_addr", 32'(bus.o_mem_addr), 32'h10);
    wait_inst(32'h1010, b);
`else
    check("nohalt_flag", 32'(bus.o_halted), 32'd0);
    check("nohalt_req", 32'(bus.o_mem_req), 32'd1);
    check("nohalt_addr", 32'(bus.o_mem_addr), 32'd4);
    wait_inst(32'h1004, b);
`endif

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
